// File: rtl/mem_ctrl_pkg.sv
// mem_ctrl_pkg
// Shared defaults and helpers for the multi-port memory controller.
// Holds the default parameter values used by multi_port_mem_ctrl and the
// port-id width function used to size grant indices and pipeline tags.
package mem_ctrl_pkg;

  localparam int DEF_NUM_PORTS  = 2;
  localparam int DEF_ADDR_W     = 16;
  localparam int DEF_DATA_W     = 16;
  localparam int DEF_DEPTH      = 256;
  localparam int DEF_RD_LATENCY = 2;

  // Width needed to hold a port index; a single port still needs one bit
  function automatic int portIdW(input int numPorts);
    return (numPorts > 1) ? $clog2(numPorts) : 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter
// Round-robin arbiter with a registered priority pointer.
// Ports:
//   clk    - clock, pointer updates on rising edge
//   reset  - asynchronous active-high reset, pointer returns to port 0
//   req    - per-port request vector
//   accept - high when the current grant is consumed; only then does the
//            pointer move past the granted port
//   grant  - combinational one-hot grant (zero when no request)
module rr_arbiter
  import mem_ctrl_pkg::*;
#(
  parameter int N = 2
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [N-1:0] req,
  input  logic         accept,
  output logic [N-1:0] grant
);

  localparam int IDW = portIdW(N);

  logic [IDW-1:0] r_ptr;
  logic [IDW-1:0] w_grantIdx;
  logic [IDW-1:0] w_nextPtr;

  // Scan ports starting at the pointer, wrapping, and grant the first requester
  always_comb begin
    int   idx;
    logic found;
    grant      = '0;
    w_grantIdx = '0;
    found      = 1'b0;
    idx        = 0;
    for (int i = 0; i < N; i++) begin
      idx = int'(r_ptr) + i;
      if (idx >= N) idx = idx - N;
      if (!found && req[idx]) begin
        grant[idx] = 1'b1;
        w_grantIdx = IDW'(idx);
        found      = 1'b1;
      end
    end
  end

  // Next priority is the port after the granted one, wrapping at N-1
  assign w_nextPtr = (int'(w_grantIdx) == N - 1) ? '0 : w_grantIdx + 1'b1;

  // Pointer register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_ptr <= '0;
    end else if (accept) begin
      r_ptr <= w_nextPtr;
    end
  end

endmodule

// File: rtl/multi_port_mem_ctrl.sv
// multi_port_mem_ctrl
// Shared single-bank memory serving NUM_PORTS requesters. One write and one
// read are accepted per cycle, each chosen by its own round-robin arbiter.
// Writes complete with a one-cycle ack; reads return through a fully
// pipelined RD_LATENCY-stage path tagged with port id and full address.
// Ports:
//   clk, reset                  - clock, async active-high reset
//   wr_en / rd_en               - per-port request bits
//   wr_address / rd_address     - packed per-port addresses (ADDR_W each)
//   wr_data                     - packed per-port write data (DATA_W each)
//   wr_ready / rd_ready         - combinational one-hot grants
//   wr_ret_ack / rd_ret_ack     - one-cycle completion pulse to owning port
//   wr_ret_address / rd_ret_address - address of the completing access
//   rd_ret_data                 - read data, valid while a rd_ret_ack bit is high
module multi_port_mem_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter int NUM_PORTS  = DEF_NUM_PORTS,
  parameter int ADDR_W     = DEF_ADDR_W,
  parameter int DATA_W     = DEF_DATA_W,
  parameter int DEPTH      = DEF_DEPTH,
  parameter int RD_LATENCY = DEF_RD_LATENCY
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [NUM_PORTS-1:0]        wr_en,
  input  logic [NUM_PORTS-1:0]        rd_en,
  input  logic [NUM_PORTS*ADDR_W-1:0] wr_address,
  input  logic [NUM_PORTS*ADDR_W-1:0] rd_address,
  input  logic [NUM_PORTS*DATA_W-1:0] wr_data,
  output logic [NUM_PORTS-1:0]        wr_ready,
  output logic [NUM_PORTS-1:0]        rd_ready,
  output logic [NUM_PORTS-1:0]        wr_ret_ack,
  output logic [NUM_PORTS-1:0]        rd_ret_ack,
  output logic [ADDR_W-1:0]           wr_ret_address,
  output logic [ADDR_W-1:0]           rd_ret_address,
  output logic [DATA_W-1:0]           rd_ret_data
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int PID_W = portIdW(NUM_PORTS);

  logic [NUM_PORTS-1:0] w_wrReq;
  logic [NUM_PORTS-1:0] w_rdReq;
  logic [NUM_PORTS-1:0] w_wrGrant;
  logic [NUM_PORTS-1:0] w_rdGrant;
  logic                 w_wrAccept;
  logic                 w_rdAccept;
  logic [PID_W-1:0]     w_wrPid;
  logic [PID_W-1:0]     w_rdPid;
  logic [ADDR_W-1:0]    w_wrAddr;
  logic [ADDR_W-1:0]    w_rdAddr;
  logic [DATA_W-1:0]    w_wrData;

  logic [DATA_W-1:0]    r_mem [DEPTH];

  logic                 r_wrAckValid;
  logic [PID_W-1:0]     r_wrAckPid;
  logic [ADDR_W-1:0]    r_wrRetAddr;

  logic                 r_pipeValid [RD_LATENCY];
  logic [PID_W-1:0]     r_pipePid   [RD_LATENCY];
  logic [ADDR_W-1:0]    r_pipeAddr  [RD_LATENCY];
  logic [DATA_W-1:0]    r_pipeData  [RD_LATENCY];

  // No grants while reset is held, so nothing is accepted or written then
  assign w_wrReq = wr_en & {NUM_PORTS{~reset}};
  assign w_rdReq = rd_en & {NUM_PORTS{~reset}};

  rr_arbiter #(.N(NUM_PORTS)) u_wrArb (
    .clk    (clk),
    .reset  (reset),
    .req    (w_wrReq),
    .accept (w_wrAccept),
    .grant  (w_wrGrant)
  );

  rr_arbiter #(.N(NUM_PORTS)) u_rdArb (
    .clk    (clk),
    .reset  (reset),
    .req    (w_rdReq),
    .accept (w_rdAccept),
    .grant  (w_rdGrant)
  );

  // A grant only exists where en is high, so any grant is an acceptance
  assign w_wrAccept = |w_wrGrant;
  assign w_rdAccept = |w_rdGrant;
  assign wr_ready   = w_wrGrant;
  assign rd_ready   = w_rdGrant;

  // Select the granted port's id, address and data
  always_comb begin
    w_wrPid  = '0;
    w_wrAddr = '0;
    w_wrData = '0;
    w_rdPid  = '0;
    w_rdAddr = '0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      if (w_wrGrant[p]) begin
        w_wrPid  = PID_W'(p);
        w_wrAddr = wr_address[p*ADDR_W +: ADDR_W];
        w_wrData = wr_data[p*DATA_W +: DATA_W];
      end
      if (w_rdGrant[p]) begin
        w_rdPid  = PID_W'(p);
        w_rdAddr = rd_address[p*ADDR_W +: ADDR_W];
      end
    end
  end

  // Storage is deliberately not reset; upper address bits wrap onto it
  always_ff @(posedge clk) begin
    if (w_wrAccept) begin
      r_mem[w_wrAddr[IDX_W-1:0]] <= w_wrData;
    end
  end

  // Write completion; address holds its last value between acks
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wrAckValid <= 1'b0;
      r_wrAckPid   <= '0;
      r_wrRetAddr  <= '0;
    end else begin
      r_wrAckValid <= w_wrAccept;
      if (w_wrAccept) begin
        r_wrAckPid  <= w_wrPid;
        r_wrRetAddr <= w_wrAddr;
      end
    end
  end

  // Read pipeline. Stage 0 samples storage at the acceptance edge, before any
  // same-edge write lands, giving read-before-write. Payload only moves with a
  // valid token so the last stage keeps its last returned address/data.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int s = 0; s < RD_LATENCY; s++) begin
        r_pipeValid[s] <= 1'b0;
        r_pipePid[s]   <= '0;
        r_pipeAddr[s]  <= '0;
        r_pipeData[s]  <= '0;
      end
    end else begin
      r_pipeValid[0] <= w_rdAccept;
      if (w_rdAccept) begin
        r_pipePid[0]  <= w_rdPid;
        r_pipeAddr[0] <= w_rdAddr;
        r_pipeData[0] <= r_mem[w_rdAddr[IDX_W-1:0]];
      end
      for (int s = 1; s < RD_LATENCY; s++) begin
        r_pipeValid[s] <= r_pipeValid[s-1];
        if (r_pipeValid[s-1]) begin
          r_pipePid[s]  <= r_pipePid[s-1];
          r_pipeAddr[s] <= r_pipeAddr[s-1];
          r_pipeData[s] <= r_pipeData[s-1];
        end
      end
    end
  end

  // Decode completion tags into per-port ack pulses
  always_comb begin
    wr_ret_ack = '0;
    rd_ret_ack = '0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      wr_ret_ack[p] = r_wrAckValid && (r_wrAckPid == PID_W'(p));
      rd_ret_ack[p] = r_pipeValid[RD_LATENCY-1] && (r_pipePid[RD_LATENCY-1] == PID_W'(p));
    end
  end

  assign wr_ret_address = r_wrRetAddr;
  assign rd_ret_address = r_pipeAddr[RD_LATENCY-1];
  assign rd_ret_data    = r_pipeData[RD_LATENCY-1];

endmodule

// File: tb/tb_multi_port_mem_ctrl.sv
// tb_multi_port_mem_ctrl
// Directed tests on the default build (2 ports, latency 2) and a random
// traffic run on a 4-port, latency-4 build against a reference memory model.
module tb_multi_port_mem_ctrl;

  // Default build
  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  wrEn, rdEn;
  logic [31:0] wrAddress, rdAddress, wrData;
  logic [1:0]  wrReady, rdReady, wrRetAck, rdRetAck;
  logic [15:0] wrRetAddress, rdRetAddress, rdRetData;

  // 4-port build: 8-bit addresses over 16 words so wrap is exercised
  logic [3:0]  bWrEn, bRdEn;
  logic [31:0] bWrAddress, bRdAddress;
  logic [63:0] bWrData;
  logic [3:0]  bWrReady, bRdReady, bWrRetAck, bRdRetAck;
  logic [7:0]  bWrRetAddress, bRdRetAddress;
  logic [15:0] bRdRetData;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  multi_port_mem_ctrl dutA (
    .clk            (clk),
    .reset          (reset),
    .wr_en          (wrEn),
    .rd_en          (rdEn),
    .wr_address     (wrAddress),
    .rd_address     (rdAddress),
    .wr_data        (wrData),
    .wr_ready       (wrReady),
    .rd_ready       (rdReady),
    .wr_ret_ack     (wrRetAck),
    .rd_ret_ack     (rdRetAck),
    .wr_ret_address (wrRetAddress),
    .rd_ret_address (rdRetAddress),
    .rd_ret_data    (rdRetData)
  );

  multi_port_mem_ctrl #(
    .NUM_PORTS(4), .ADDR_W(8), .DATA_W(16), .DEPTH(16), .RD_LATENCY(4)
  ) dutB (
    .clk            (clk),
    .reset          (reset),
    .wr_en          (bWrEn),
    .rd_en          (bRdEn),
    .wr_address     (bWrAddress),
    .rd_address     (bRdAddress),
    .wr_data        (bWrData),
    .wr_ready       (bWrReady),
    .rd_ready       (bRdReady),
    .wr_ret_ack     (bWrRetAck),
    .rd_ret_ack     (bRdRetAck),
    .wr_ret_address (bWrRetAddress),
    .rd_ret_address (bRdRetAddress),
    .rd_ret_data    (bRdRetData)
  );

  // Advance to just after the next rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clearInputs();
    wrEn = '0; rdEn = '0; wrAddress = '0; rdAddress = '0; wrData = '0;
    bWrEn = '0; bRdEn = '0; bWrAddress = '0; bRdAddress = '0; bWrData = '0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    clearInputs();
    tick();
    tick();
    checks++; if (wrRetAck !== 2'b00) begin errors++; $display("[TB] FAIL reset_wr_ack: got %b expected 00", wrRetAck); end
    checks++; if (rdRetAck !== 2'b00) begin errors++; $display("[TB] FAIL reset_rd_ack: got %b expected 00", rdRetAck); end
    checks++; if (wrRetAddress !== 16'h0) begin errors++; $display("[TB] FAIL reset_wr_addr: got %h expected 0000", wrRetAddress); end
    checks++; if (rdRetAddress !== 16'h0) begin errors++; $display("[TB] FAIL reset_rd_addr: got %h expected 0000", rdRetAddress); end
    checks++; if (rdRetData !== 16'h0) begin errors++; $display("[TB] FAIL reset_rd_data: got %h expected 0000", rdRetData); end
    checks++; if (bRdRetAck !== 4'h0 || bRdRetData !== 16'h0) begin errors++; $display("[TB] FAIL reset_b_rd: ack %b data %h expected 0/0", bRdRetAck, bRdRetData); end
    // Release and request immediately: must be accepted on the first edge
    reset = 1'b0;
    wrEn = 2'b01; wrAddress[0 +: 16] = 16'h0042; wrData[0 +: 16] = 16'h0042;
    #1;
    checks++; if (wrReady !== 2'b01) begin errors++; $display("[TB] FAIL post_reset_ready: got %b expected 01", wrReady); end
    tick();
    wrEn = '0;
    checks++; if (wrRetAck !== 2'b01) begin errors++; $display("[TB] FAIL post_reset_ack: got %b expected 01", wrRetAck); end
  endtask

  task automatic test_write_read();
    wrEn = 2'b01; wrAddress[0 +: 16] = 16'd150; wrData[0 +: 16] = 16'h1234;
    #1;
    checks++; if (wrReady !== 2'b01 || rdReady !== 2'b00) begin errors++; $display("[TB] FAIL wr_ready: got %b/%b expected 01/00", wrReady, rdReady); end
    tick();
    checks++; if (wrRetAck !== 2'b01) begin errors++; $display("[TB] FAIL wr_ack: got %b expected 01", wrRetAck); end
    checks++; if (wrRetAddress !== 16'd150) begin errors++; $display("[TB] FAIL wr_ret_addr: got %0d expected 150", wrRetAddress); end
    wrEn = '0; rdEn = 2'b10; rdAddress[16 +: 16] = 16'd150;
    #1;
    checks++; if (rdReady !== 2'b10) begin errors++; $display("[TB] FAIL rd_ready_p1: got %b expected 10", rdReady); end
    tick();
    rdEn = '0;
    checks++; if (rdRetAck !== 2'b00) begin errors++; $display("[TB] FAIL rd_ack_early: got %b expected 00", rdRetAck); end
    tick();
    checks++; if (rdRetAck !== 2'b10) begin errors++; $display("[TB] FAIL rd_ack_p1: got %b expected 10", rdRetAck); end
    checks++; if (rdRetAddress !== 16'd150) begin errors++; $display("[TB] FAIL rd_ret_addr: got %0d expected 150", rdRetAddress); end
    checks++; if (rdRetData !== 16'h1234) begin errors++; $display("[TB] FAIL rd_data_1234: got %h expected 1234", rdRetData); end
    tick();
    checks++; if (rdRetAck !== 2'b00 || wrRetAck !== 2'b00) begin errors++; $display("[TB] FAIL ack_single_pulse: got %b/%b expected 00/00", rdRetAck, wrRetAck); end
    checks++; if (rdRetAddress !== 16'd150 || rdRetData !== 16'h1234) begin errors++; $display("[TB] FAIL ret_hold: got %0d/%h expected 150/1234", rdRetAddress, rdRetData); end
  endtask

  task automatic test_back_to_back();
    logic [1:0]  expAck;
    logic [15:0] expAddr, expData;
    int          ackSeen;
    ackSeen = 0;
    wrEn = 2'b01; wrAddress[0 +: 16] = 16'd20; wrData[0 +: 16] = 16'hA020;
    tick();
    wrEn = 2'b10; wrAddress[16 +: 16] = 16'd21; wrData[16 +: 16] = 16'hB021;
    tick();
    wrEn = '0;
    rdAddress[0 +: 16] = 16'd20; rdAddress[16 +: 16] = 16'd21;
    for (int k = 0; k < 9; k++) begin
      rdEn = (k < 8) ? 2'b11 : 2'b00;
      #1;
      if (k < 8) begin
        checks++;
        if (rdReady !== ((k % 2 == 0) ? 2'b01 : 2'b10)) begin
          errors++; $display("[TB] FAIL b2b_grant_%0d: got %b expected %b", k, rdReady, (k % 2 == 0) ? 2'b01 : 2'b10);
        end
      end
      tick();
      if (k >= 1) begin
        expAck  = ((k - 1) % 2 == 0) ? 2'b01 : 2'b10;
        expAddr = ((k - 1) % 2 == 0) ? 16'd20 : 16'd21;
        expData = ((k - 1) % 2 == 0) ? 16'hA020 : 16'hB021;
        if (rdRetAck !== 2'b00) ackSeen++;
        checks++;
        if (rdRetAck !== expAck || rdRetAddress !== expAddr || rdRetData !== expData) begin
          errors++; $display("[TB] FAIL b2b_ret_%0d: got %b/%0d/%h expected %b/%0d/%h", k - 1, rdRetAck, rdRetAddress, rdRetData, expAck, expAddr, expData);
        end
      end
    end
    tick();
    checks++; if (rdRetAck !== 2'b00) begin errors++; $display("[TB] FAIL b2b_tail: got %b expected 00", rdRetAck); end
    checks++; if (ackSeen != 8) begin errors++; $display("[TB] FAIL b2b_count: got %0d expected 8", ackSeen); end
  endtask

  task automatic test_same_cycle();
    wrEn = 2'b01; wrAddress[0 +: 16] = 16'd5; wrData[0 +: 16] = 16'h0001;
    tick();
    wrData[0 +: 16] = 16'hBEEF;
    rdEn = 2'b10; rdAddress[16 +: 16] = 16'd5;
    #1;
    checks++; if (wrReady !== 2'b01 || rdReady !== 2'b10) begin errors++; $display("[TB] FAIL rbw_grants: got %b/%b expected 01/10", wrReady, rdReady); end
    tick();
    wrEn = '0; rdEn = 2'b01; rdAddress[0 +: 16] = 16'd5;
    tick();
    rdEn = '0;
    checks++; if (rdRetAck !== 2'b10 || rdRetData !== 16'h0001) begin errors++; $display("[TB] FAIL rbw_old: got %b/%h expected 10/0001", rdRetAck, rdRetData); end
    tick();
    checks++; if (rdRetAck !== 2'b01 || rdRetData !== 16'hBEEF) begin errors++; $display("[TB] FAIL rbw_new: got %b/%h expected 01/beef", rdRetAck, rdRetData); end
  endtask

  task automatic test_wrap();
    wrEn = 2'b10; wrAddress[16 +: 16] = 16'h0105; wrData[16 +: 16] = 16'h5A5A;
    tick();
    wrEn = '0;
    checks++; if (wrRetAck !== 2'b10 || wrRetAddress !== 16'h0105) begin errors++; $display("[TB] FAIL wrap_wr_ret: got %b/%h expected 10/0105", wrRetAck, wrRetAddress); end
    rdEn = 2'b01; rdAddress[0 +: 16] = 16'h0005;
    tick();
    rdEn = '0;
    tick();
    checks++; if (rdRetAck !== 2'b01 || rdRetAddress !== 16'h0005 || rdRetData !== 16'h5A5A) begin errors++; $display("[TB] FAIL wrap_rd: got %b/%h/%h expected 01/0005/5a5a", rdRetAck, rdRetAddress, rdRetData); end
  endtask

  task automatic test_write_rr();
    logic [1:0] expGrant;
    wrEn = 2'b11;
    wrAddress[0 +: 16] = 16'd30; wrAddress[16 +: 16] = 16'd31;
    wrData = 32'h3131_3030;
    for (int k = 0; k < 4; k++) begin
      expGrant = (k % 2 == 0) ? 2'b01 : 2'b10;
      #1;
      checks++; if (wrReady !== expGrant) begin errors++; $display("[TB] FAIL wr_rr_grant_%0d: got %b expected %b", k, wrReady, expGrant); end
      tick();
      checks++;
      if (wrRetAck !== expGrant || wrRetAddress !== ((k % 2 == 0) ? 16'd30 : 16'd31)) begin
        errors++; $display("[TB] FAIL wr_rr_ack_%0d: got %b/%0d expected %b/%0d", k, wrRetAck, wrRetAddress, expGrant, (k % 2 == 0) ? 30 : 31);
      end
    end
    wrEn = '0;
  endtask

  task automatic test_reset_midflight();
    int lateAcks;
    lateAcks = 0;
    rdEn = 2'b01; rdAddress[0 +: 16] = 16'd20;
    tick();
    rdEn = '0;
    reset = 1'b1;
    #1;
    checks++; if (rdRetAck !== 2'b00 || wrRetAck !== 2'b00) begin errors++; $display("[TB] FAIL midreset_acks: got %b/%b expected 00/00", rdRetAck, wrRetAck); end
    checks++; if (rdRetAddress !== 16'h0 || wrRetAddress !== 16'h0 || rdRetData !== 16'h0) begin errors++; $display("[TB] FAIL midreset_ret: got %h/%h/%h expected 0/0/0", rdRetAddress, wrRetAddress, rdRetData); end
    tick();
    reset = 1'b0;
    for (int k = 0; k < 5; k++) begin
      tick();
      if (rdRetAck !== 2'b00) lateAcks++;
    end
    checks++; if (lateAcks != 0) begin errors++; $display("[TB] FAIL midreset_discard: got %0d acks expected 0", lateAcks); end
  endtask

  task automatic test_random_4port();
    logic [15:0] mMem   [16];
    bit          mKnown [16];
    bit          eValid [4];
    int          ePid   [4];
    logic [7:0]  eAddr  [4];
    logic [15:0] eData  [4];
    bit          eKnown [4];
    int          wrPtr, rdPtr, wg, rg, idx;
    logic [7:0]  wAddr, rAddr;
    logic [15:0] wData;
    logic [3:0]  expW, expR, expAck;
    wrPtr = 0; rdPtr = 0;
    for (int i = 0; i < 16; i++) mKnown[i] = 1'b0;
    for (int s = 0; s < 4; s++) begin eValid[s] = 1'b0; ePid[s] = 0; eAddr[s] = '0; eData[s] = '0; eKnown[s] = 1'b0; end
    for (int cyc = 0; cyc < 300; cyc++) begin
      bWrEn = 4'($urandom_range(0, 15));
      bRdEn = 4'($urandom_range(0, 15));
      for (int p = 0; p < 4; p++) begin
        bWrAddress[p*8 +: 8] = 8'($urandom_range(0, 31));
        bRdAddress[p*8 +: 8] = 8'($urandom_range(0, 31));
        bWrData[p*16 +: 16]  = 16'($urandom);
      end
      wg = -1; rg = -1;
      for (int i = 0; i < 4; i++) begin
        idx = (wrPtr + i) % 4;
        if (wg < 0 && bWrEn[idx]) wg = idx;
        idx = (rdPtr + i) % 4;
        if (rg < 0 && bRdEn[idx]) rg = idx;
      end
      expW = (wg < 0) ? 4'b0 : 4'(1 << wg);
      expR = (rg < 0) ? 4'b0 : 4'(1 << rg);
      #1;
      checks++; if (bWrReady !== expW || bRdReady !== expR) begin errors++; $display("[TB] FAIL rand_grant_%0d: got %b/%b expected %b/%b", cyc, bWrReady, bRdReady, expW, expR); end
      wAddr = (wg < 0) ? 8'h0 : bWrAddress[wg*8 +: 8];
      wData = (wg < 0) ? 16'h0 : bWrData[wg*16 +: 16];
      rAddr = (rg < 0) ? 8'h0 : bRdAddress[rg*8 +: 8];
      // Shift expected read pipeline; entry 0 sees storage before this write
      for (int s = 3; s > 0; s--) begin
        eValid[s] = eValid[s-1]; ePid[s] = ePid[s-1]; eAddr[s] = eAddr[s-1];
        eData[s] = eData[s-1]; eKnown[s] = eKnown[s-1];
      end
      eValid[0] = (rg >= 0); ePid[0] = rg; eAddr[0] = rAddr;
      eData[0] = mMem[rAddr[3:0]]; eKnown[0] = mKnown[rAddr[3:0]];
      if (wg >= 0) begin
        mMem[wAddr[3:0]] = wData; mKnown[wAddr[3:0]] = 1'b1; wrPtr = (wg + 1) % 4;
      end
      if (rg >= 0) rdPtr = (rg + 1) % 4;
      tick();
      checks++; if (bWrRetAck !== expW || (wg >= 0 && bWrRetAddress !== wAddr)) begin errors++; $display("[TB] FAIL rand_wr_ret_%0d: got %b/%h expected %b/%h", cyc, bWrRetAck, bWrRetAddress, expW, wAddr); end
      expAck = eValid[3] ? 4'(1 << ePid[3]) : 4'b0;
      checks++;
      if (bRdRetAck !== expAck || (eValid[3] && bRdRetAddress !== eAddr[3]) ||
          (eValid[3] && eKnown[3] && bRdRetData !== eData[3])) begin
        errors++; $display("[TB] FAIL rand_rd_ret_%0d: got %b/%h/%h expected %b/%h/%h", cyc, bRdRetAck, bRdRetAddress, bRdRetData, expAck, eAddr[3], eData[3]);
      end
    end
    bWrEn = '0; bRdEn = '0;
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_back_to_back();
    test_same_cycle();
    test_wrap();
    test_write_rr();
    test_reset_midflight();
    test_random_4port();
    tick();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
